// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity mode
// constants, serializer state encoding and a frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Clocks one complete frame occupies on the line.
    function automatic int frame_clks(input int clks_per_bit, input int data_bits,
                                      input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO that buffers payload words ahead of the serializer.
// Pointers carry one extra wrap bit so full and empty are told apart.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input, busy flag and a
// done pulse on the last clock of the final stop bit.
// Optional input buffering: define UART_TX_FIFO_EN to place a FIFO_DEPTH
// entry FIFO in front of the serializer.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line high, waiting for a word to accept
// ST_START  | start bit (low) for CLKS_PER_BIT clocks
// ST_DATA   | payload, LSB first, CLKS_PER_BIT clocks per bit
// ST_PARITY | parity bit (only when PARITY != none)
// ST_STOP   | STOP_BITS stop bits (high); tx_done on the very last clock
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 bit_out
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 bit_end;
    logic                 src_valid;
    logic                 src_take;
    logic [DATA_BITS-1:0] src_data;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (src_take),
        .rd_data (src_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign src_valid = !fifo_empty;
    assign tx_ready  = !fifo_full;
    assign tx_busy   = (state_q != ST_IDLE) || !fifo_empty;
`else
    assign src_valid = tx_valid;
    assign src_data  = tx_data;
    assign tx_ready  = (state_q == ST_IDLE);
    assign tx_busy   = (state_q != ST_IDLE);
`endif

    assign src_take = (state_q == ST_IDLE) && src_valid;
    assign bit_end  = (cnt_q == CNT_LAST);
    assign tx_done  = (state_q == ST_STOP) && bit_end && (idx_q == STOP_LAST);
    assign bit_out  = line_q;

    // Next-state, counters and the registered line level for the next clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        line_d  = 1'b1;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (src_take) begin
                    state_d = ST_START;
                    shift_d = src_data;
                    par_d   = (PARITY == PARITY_ODD) ? ~^src_data : ^src_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line is registered so the pin never glitches on state changes.
        unique case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset drops any in-flight frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three differently parametrised
// instances, directed frames plus randomized back-to-back streams, all
// compared against a frame-level reference model.
module tb_uart_tx_param;

    localparam int C0 = 16, DB0 = 8, P0 = 0, S0 = 1;
    localparam int C1 = 4,  DB1 = 7, P1 = 2, S1 = 2;
    localparam int C2 = 3,  DB2 = 9, P2 = 1, S2 = 1;
    localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      vin;
    logic [2:0]      rdy, bsy, dn, ln;
    logic [2:0][8:0] din;
    int              n_total = 0;
    int              n_bad = 0;
    int unsigned     sbytes [8];

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(C0), .DATA_BITS(DB0), .PARITY(P0), .STOP_BITS(S0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[0][DB0-1:0]), .tx_valid(vin[0]),
        .tx_ready(rdy[0]), .tx_busy(bsy[0]), .tx_done(dn[0]), .bit_out(ln[0]));

    uart_tx_param #(.CLKS_PER_BIT(C1), .DATA_BITS(DB1), .PARITY(P1), .STOP_BITS(S1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[1][DB1-1:0]), .tx_valid(vin[1]),
        .tx_ready(rdy[1]), .tx_busy(bsy[1]), .tx_done(dn[1]), .bit_out(ln[1]));

    uart_tx_param #(.CLKS_PER_BIT(C2), .DATA_BITS(DB2), .PARITY(P2), .STOP_BITS(S2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[2][DB2-1:0]), .tx_valid(vin[2]),
        .tx_ready(rdy[2]), .tx_busy(bsy[2]), .tx_done(dn[2]), .bit_out(ln[2]));

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int p_clk(input int i);
        case (i) 0: return C0; 1: return C1; default: return C2; endcase
    endfunction
    function automatic int p_db(input int i);
        case (i) 0: return DB0; 1: return DB1; default: return DB2; endcase
    endfunction
    function automatic int p_par(input int i);
        case (i) 0: return P0; 1: return P1; default: return P2; endcase
    endfunction
    function automatic int p_stop(input int i);
        case (i) 0: return S0; 1: return S1; default: return S2; endcase
    endfunction

    function automatic int flen(input int i);
        return p_clk(i) * (1 + p_db(i) + ((p_par(i) != 0) ? 1 : 0) + p_stop(i));
    endfunction

    // Level of serial bit number b (0 = start) in a frame carrying d.
    function automatic logic frame_bit(input int i, input int unsigned d, input int b);
        int db;
        int ones;
        db   = p_db(i);
        ones = 0;
        if (b == 0) return 1'b0;
        if (b <= db) return d[b-1];
        if (p_par(i) != 0 && b == db + 1) begin
            for (int k = 0; k < db; k++) ones += int'(d[k]);
            if (p_par(i) == 2) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    // Offer sbytes[0..n-1] to instance i as fast as it takes them, record every
    // clock, and compare against the expected back-to-back frame train.
    task automatic stream(input int i, input int n, output logic [511:0] o_line);
        logic [511:0] o_done, o_busy, o_rdy, e_line, e_done, e_busy, e_rdy;
        int L, c, total, ptr, full_at, base;
        L = flen(i);
        c = p_clk(i);
        total = LAT + n * (L + 1);
        o_line = '0; o_done = '0; o_busy = '0; o_rdy = '0;
        e_line = '0; e_done = '0; e_busy = '0; e_rdy = '0;
        ptr = 0;
        full_at = -1;
        for (int t = 0; t < total; t++) begin
            @(negedge clk);
            o_line[t] = ln[i];
            o_done[t] = dn[i];
            o_busy[t] = bsy[i];
            o_rdy[t]  = rdy[i];
            if (!rdy[i] && full_at < 0) full_at = ptr;
            vin[i] = (ptr < n);
            if (ptr < n) din[i] = 9'(sbytes[ptr]);
            if (ptr < n && rdy[i]) ptr++;
        end
        vin[i] = 1'b0;

        for (int t = 0; t < total; t++) begin
            e_line[t] = 1'b1;
            e_rdy[t]  = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            base = LAT + k * (L + 1);
            for (int t = 0; t < L; t++) begin
                e_line[base + t] = frame_bit(i, sbytes[k], t / c);
                e_busy[base + t] = 1'b1;
                e_rdy[base + t]  = 1'b0;
            end
            e_done[base + L - 1] = 1'b1;
        end
`ifdef UART_TX_FIFO_EN
        for (int t = 1; t < total - 1; t++) e_busy[t] = 1'b1;
`endif
        chk($sformatf("d%0d_line", i), o_line, e_line);
        chk($sformatf("d%0d_done", i), o_done, e_done);
        chk($sformatf("d%0d_busy", i), o_busy, e_busy);
        chk($sformatf("d%0d_accepted", i), 512'(ptr), 512'(n));
`ifdef UART_TX_FIFO_EN
        if (n > DEPTH) chk($sformatf("d%0d_fill", i), 512'(full_at), 512'(DEPTH + 1));
`else
        chk($sformatf("d%0d_ready", i), o_rdy, e_rdy);
`endif
    endtask

    // Reset in the middle of data bit 3 of a frame whose bit 3 is low.
    task automatic mid_reset_test();
        logic [511:0] lv;
        int t_hit;
        sbytes[0] = $urandom_range(0, 255) & 32'hF7;
        t_hit = LAT + C0 * 4 + 5;
        @(negedge clk);
        vin[0] = 1'b1;
        din[0] = 9'(sbytes[0]);
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (t_hit - 1) @(negedge clk);
        chk("rst_pre_line", 512'(ln[0]), 512'(0));
        chk("rst_pre_busy", 512'(bsy[0]), 512'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_line", 512'(ln[0]), 512'(1));
        chk("rst_mid_busy", 512'(bsy[0]), 512'(0));
        chk("rst_mid_ready", 512'(rdy[0]), 512'(1));
        chk("rst_mid_done", 512'(dn[0]), 512'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        sbytes[0] = 32'h3C;
        stream(0, 1, lv);
    endtask

    initial begin
        logic [511:0] lv;
        logic [9:0]   seq;
        int           n;
        rst_n = 1'b1;
        vin   = '0;
        din   = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_line",  512'(ln),  512'(3'b111));
        chk("rst_busy",  512'(bsy), 512'(3'b000));
        chk("rst_done",  512'(dn),  512'(3'b000));
        chk("rst_ready", 512'(rdy), 512'(3'b111));
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_line", 512'(ln), 512'(3'b111));

        // 8N1 frame of 0xA5, mid-bit samples against the literal bit pattern.
        sbytes[0] = 32'hA5;
        stream(0, 1, lv);
        for (int b = 0; b < 10; b++) seq[b] = lv[LAT + b * C0 + C0 / 2];
        chk("d0_a5_seq", 512'(seq), 512'(10'b1101001010));

        // Even parity of 0x07 is 1; odd parity of 0x07 is 0.
        sbytes[0] = 32'h07;
        stream(1, 1, lv);
        chk("d1_even_par", 512'(lv[LAT + (1 + DB1) * C1 + C1 / 2]), 512'(1));
        sbytes[0] = 32'h07;
        stream(2, 1, lv);
        chk("d2_odd_par", 512'(lv[LAT + (1 + DB2) * C2 + C2 / 2]), 512'(0));

        // Seven data ones followed by parity and two stop bits.
        sbytes[0] = 32'h7F;
        stream(1, 1, lv);

        // Back-to-back with valid held.
        sbytes[0] = 32'h55;
        sbytes[1] = 32'hAA;
        stream(0, 2, lv);

        // Six words offered continuously (fills the FIFO when present).
        for (int k = 0; k < 6; k++) sbytes[k] = $urandom & 32'h7F;
        stream(1, 6, lv);

        mid_reset_test();

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) sbytes[k] = $urandom & ((32'd1 << p_db(i)) - 1);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                stream(i, n, lv);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
